dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core's data port: the memory side of the core's load/store traffic. Accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs a byte-lane write or a full-word read. It returns each result, with an error flag, over a second valid/ready handshake. It replaces the bare block RAM on the data side so the core can be tested against slow or stalling memory.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_bytelane_ram.sv | 38 +++
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the wait-counter width and the legal byte-strobe set.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int CNT_W = 4;

  localparam logic [3:0] STRB_READ = 4'b0000;
  localparam logic [3:0] STRB_B0   = 4'b0001;
  localparam logic [3:0] STRB_B1   = 4'b0010;
  localparam logic [3:0] STRB_B2   = 4'b0100;
  localparam logic [3:0] STRB_B3   = 4'b1000;
  localparam logic [3:0] STRB_H0   = 4'b0011;
  localparam logic [3:0] STRB_H1   = 4'b1100;
  localparam logic [3:0] STRB_W    = 4'b1111;

  // Only naturally aligned byte, halfword and word writes are legal.
  function automatic logic wstrb_legal(input logic [3:0] strb);
    case (strb)
      STRB_READ, STRB_B0, STRB_B1, STRB_B2, STRB_B3,
      STRB_H0, STRB_H1, STRB_W: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// The read register only loads on a read access so it holds until the next read.
module dmem_bytelane_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_en && (i_we == 4'b0000)) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the core's data port: one request in flight, programmable wait
// states, byte-lane writes / word reads, response with error flag over valid/ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_err, r_rd_ok;

  logic             w_accept, w_access, w_legal;
  logic [31:0]      w_addr, w_wdata, w_offset, w_ram_rdata;
  logic [3:0]       w_wstrb;

  assign w_accept = req_valid && (r_state == IDLE);

  // With zero wait states the access happens on the acceptance edge, before capture.
  assign w_addr   = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wstrb  = (r_state == IDLE) ? req_wstrb : r_wstrb;
  assign w_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_offset = w_addr - BASE_ADDR;
  assign w_legal  = ({1'b0, w_offset} < SPAN) && wstrb_legal(w_wstrb);

  // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_access = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next   = RESP;
            w_access = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next   = RESP;
          w_access = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= CNT_W'(WAIT_CYCLES);
      r_addr  <= req_addr;
      r_wstrb <= req_wstrb;
      r_wdata <= req_wdata;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Response flags are decided on the access edge and held until the next access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else if (w_access) begin
      r_err   <= !w_legal;
      r_rd_ok <= w_legal && (w_wstrb == STRB_READ);
    end
  end

  dmem_bytelane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_access && w_legal),
    .i_we   (w_wstrb),
    .i_addr (w_offset[AW+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rd_ok ? w_ram_rdata : 32'h0;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 has two wait states, instance 1 none.
// Expected responses come from a small memory model and are queued at acceptance.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rq_valid [2];
  logic        rq_ready [2];
  logic [31:0] rq_addr  [2];
  logic [3:0]  rq_wstrb [2];
  logic [31:0] rq_wdata [2];
  logic        rs_valid [2];
  logic        rp_ready [2];
  logic [31:0] rs_rdata [2];
  logic        rs_err   [2];

  exp_t        sb_q[$];
  logic [31:0] model [int];
  int          cyc = 0;
  int          last_acc = 0;
  logic [31:0] last_rdata;
  int          n_checks = 0;
  int          n_errors = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rq_valid[0]), .req_ready(rq_ready[0]), .req_addr(rq_addr[0]),
    .req_wstrb(rq_wstrb[0]), .req_wdata(rq_wdata[0]),
    .resp_valid(rs_valid[0]), .resp_ready(rp_ready[0]),
    .resp_rdata(rs_rdata[0]), .resp_err(rs_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rq_valid[1]), .req_ready(rq_ready[1]), .req_addr(rq_addr[1]),
    .req_wstrb(rq_wstrb[1]), .req_wdata(rq_wdata[1]),
    .resp_valid(rs_valid[1]), .resp_ready(rp_ready[1]),
    .resp_rdata(rs_rdata[1]), .resp_err(rs_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference behaviour: legality, lane merge into the model, queued expectation.
  task automatic predict(input int d, input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata);
    exp_t        e;
    int          key;
    logic        legal;
    logic [31:0] w;
    key   = d * 65536 + int'(addr >> 2);
    legal = (addr < 32'd4096) &&
            (wstrb inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b0011, 4'b1100, 4'b1111});
    e.err   = !legal;
    e.rdata = 32'h0;
    w       = model.exists(key) ? model[key] : 32'hx;
    if (legal && wstrb == 4'b0000) begin
      e.rdata = w;
    end else if (legal) begin
      for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      model[key] = w;
    end
    sb_q.push_back(e);
  endtask

  task automatic issue(input int d, input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input bit expect_resp);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    rq_valid[d] = 1'b1;
    rq_addr[d]  = addr;
    rq_wstrb[d] = wstrb;
    rq_wdata[d] = wdata;
    for (int i = 0; i < 50; i++) begin
      if (rq_ready[d]) begin
        acc      = 1'b1;
        last_acc = cyc;
      end
      @(posedge clk);
      #1;
      if (acc) break;
      @(negedge clk);
    end
    rq_valid[d] = 1'b0;
    check("accept", 32'(acc), 32'd1);
    if (acc && expect_resp) predict(d, addr, wstrb, wdata);
  endtask

  // Waits for the response, optionally stalls it for 'hold' cycles, then handshakes once.
  task automatic collect(input int d, input int hold);
    bit          seen;
    logic [31:0] d0;
    exp_t        e;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (rs_valid[d]) seen = 1'b1;
    end
    check("resp_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check("latency", 32'(cyc - last_acc), 32'(wait_of(d) + 1));
    d0 = rs_rdata[d];
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        rq_valid[d] = 1'b1;
        rq_addr[d]  = 32'h40;
        rq_wstrb[d] = 4'b1111;
        rq_wdata[d] = 32'hDEADBEEF;
      end else begin
        rq_valid[d] = 1'b0;
      end
      @(negedge clk);
      check("bp_valid", 32'(rs_valid[d]), 32'd1);
      check("bp_rdata", rs_rdata[d], d0);
      check("bp_req_ready", 32'(rq_ready[d]), 32'd0);
    end
    rq_valid[d] = 1'b0;
    rp_ready[d] = 1'b1;
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("rdata", rs_rdata[d], e.rdata);
      check("err", 32'(rs_err[d]), 32'(e.err));
    end
    last_rdata = rs_rdata[d];
    @(posedge clk);
    #1;
    rp_ready[d] = 1'b0;
    check("idle_valid", 32'(rs_valid[d]), 32'd0);
    check("idle_ready", 32'(rq_ready[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b_addr [4];
    int          acc_c [4];
    int          rsp_c [4];
    int          n_acc, n_rsp;
    exp_t        e;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rq_valid[d] = 1'b0;
      rq_addr[d]  = '0;
      rq_wstrb[d] = '0;
      rq_wdata[d] = '0;
      rp_ready[d] = 1'b0;
    end
    #3;
    check("rst_req_ready", 32'(rq_ready[0]), 32'd1);
    check("rst_resp_valid", 32'(rs_valid[0]), 32'd0);
    check("rst_rdata", rs_rdata[0], 32'h0);
    check("rst_err", 32'(rs_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Word write then read back.
    issue(0, 32'h10, 4'b1111, 32'h12345678, 1'b1); collect(0, 0);
    issue(0, 32'h10, 4'b0000, 32'h0, 1'b1);        collect(0, 0);
    check("word_read", last_rdata, 32'h12345678);

    // Byte and halfword lane merge.
    issue(0, 32'h14, 4'b1111, 32'hFFFFFFFF, 1'b1); collect(0, 0);
    issue(0, 32'h14, 4'b0010, 32'h0000AB00, 1'b1); collect(0, 0);
    issue(0, 32'h14, 4'b1100, 32'hCDEF0000, 1'b1); collect(0, 0);
    issue(0, 32'h14, 4'b0000, 32'h0, 1'b1);        collect(0, 0);
    check("lane_merge", last_rdata, 32'hCDEFABFF);

    // Out-of-range read and illegal strobe.
    issue(0, 32'h1000, 4'b0000, 32'h0, 1'b1);        collect(0, 0);
    issue(0, 32'h10, 4'b0101, 32'hAAAAAAAA, 1'b1);   collect(0, 0);
    issue(0, 32'h10, 4'b0000, 32'h0, 1'b1);          collect(0, 0);

    // Backpressure with an ignored request pulse aimed at 0x40.
    issue(0, 32'h40, 4'b1111, 32'h11112222, 1'b1); collect(0, 0);
    issue(0, 32'h10, 4'b0000, 32'h0, 1'b1);        collect(0, 10);
    issue(0, 32'h40, 4'b0000, 32'h0, 1'b1);        collect(0, 0);

    // Asynchronous reset while a write waits.
    issue(0, 32'h20, 4'b1111, 32'h55AA55AA, 1'b1); collect(0, 0);
    issue(0, 32'h20, 4'b0000, 32'h0, 1'b1);        collect(0, 0);
    issue(0, 32'h20, 4'b1111, 32'hFFFFFFFF, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rs_valid[0]), 32'd0);
    check("mid_rst_ready", 32'(rq_ready[0]), 32'd1);
    check("mid_rst_rdata", rs_rdata[0], 32'h0);
    check("mid_rst_err", 32'(rs_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue(0, 32'h20, 4'b0000, 32'h0, 1'b1); collect(0, 0);
    check("old_data", last_rdata, 32'h55AA55AA);

    // Zero wait states: preload, then back-to-back reads with resp_ready high.
    for (int i = 0; i < 4; i++) begin
      b2b_addr[i] = 32'h80 + 32'(4 * i);
      issue(1, b2b_addr[i], 4'b1111, 32'hA0B0C000 + 32'(i * 17), 1'b1);
      collect(1, 0);
    end
    n_acc = 0;
    n_rsp = 0;
    @(negedge clk);
    rp_ready[1] = 1'b1;
    rq_valid[1] = 1'b1;
    rq_wstrb[1] = 4'b0000;
    rq_addr[1]  = b2b_addr[0];
    for (int c = 0; c < 40 && n_rsp < 4; c++) begin
      if (rs_valid[1]) begin
        rsp_c[n_rsp] = cyc;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("b2b_rdata", rs_rdata[1], e.rdata);
          check("b2b_err", 32'(rs_err[1]), 32'(e.err));
        end
        n_rsp++;
      end
      if (rq_valid[1] && rq_ready[1]) begin
        acc_c[n_acc] = cyc;
        predict(1, b2b_addr[n_acc], 4'b0000, 32'h0);
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (n_acc >= 4) rq_valid[1] = 1'b0;
      else            rq_addr[1]  = b2b_addr[n_acc];
      @(negedge clk);
    end
    rq_valid[1] = 1'b0;
    rp_ready[1] = 1'b0;
    check("b2b_count", 32'(n_rsp), 32'd4);
    if (n_rsp == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_latency", 32'(rsp_c[i] - acc_c[i]), 32'd1);
        if (i > 0) check("b2b_spacing", 32'(acc_c[i] - acc_c[i-1]), 32'd2);
      end
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
